// File: rtl/imem_fetch_ctrl.sv
// Instruction memory sequencer: boot-time LOAD of program words, then RUN-phase
// PC ownership with one fetch per cycle, stall hold and redirect bubbles.
module imem_fetch_ctrl #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP       = 32'h0000_0013,
  parameter bit          SKIP_LOAD = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        running
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = AW + 2;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   w_wr_ptr_nxt;
  logic [BW-1:0]   r_pc;
  logic [BW-1:0]   w_pc_nxt;
  logic [BW-1:0]   r_if_pc;
  logic [BW-1:0]   w_if_pc_nxt;
  logic [31:0]     r_if_instr;
  logic [31:0]     w_if_instr_nxt;
  logic            r_if_valid;
  logic            w_if_valid_nxt;
  logic            w_unused;

  // PC is kept modulo DEPTH*4; address bits above that and the byte offset are dropped.
  assign w_unused = ^{redirect_pc[31:BW], redirect_pc[1:0]};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= SKIP_LOAD ? ST_RUN : ST_LOAD;
      r_wr_ptr   <= '0;
      r_pc       <= BW'(RESET_PC);
      r_if_pc    <= '0;
      r_if_instr <= NOP;
      r_if_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_pc       <= w_pc_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_if_valid <= w_if_valid_nxt;
    end
  end

  // Next-state, fetch decision and memory-port drive.
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_pc_nxt       = r_pc;
    w_if_pc_nxt    = r_if_pc;
    w_if_instr_nxt = r_if_instr;
    w_if_valid_nxt = r_if_valid;
    ld_ready       = 1'b0;
    mem_we         = 1'b0;
    mem_wdata      = '0;
    mem_addr       = 32'(r_pc);

    unique case (r_state)
      ST_LOAD: begin
        ld_ready  = 1'b1;
        mem_addr  = 32'({r_wr_ptr, 2'b00});
        mem_wdata = ld_data;
        // A write in the reset cycle must not land in memory.
        mem_we    = ld_valid & rst_n;
        if (ld_valid) begin
          w_wr_ptr_nxt = r_wr_ptr + AW'(1);
          if (ld_last || (r_wr_ptr == AW'(DEPTH - 1))) begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (redirect) begin
          w_pc_nxt       = {redirect_pc[BW-1:2], 2'b00};
          w_if_pc_nxt    = r_pc;
          w_if_instr_nxt = NOP;
          w_if_valid_nxt = 1'b0;
        end else if (!stall) begin
          w_pc_nxt       = r_pc + BW'(4);
          w_if_pc_nxt    = r_pc;
          w_if_instr_nxt = mem_rdata;
          w_if_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  assign if_pc    = 32'(r_if_pc);
  assign if_instr = r_if_instr;
  assign if_valid = r_if_valid;
  assign running  = (r_state == ST_RUN);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl (DEPTH=8): driver queues hand-computed
// per-cycle output snapshots, a negedge monitor pops and compares them.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  typedef struct packed {
    logic        running;
    logic        ld_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        running;

  logic [31:0] imem [0:7];
  obs_t        exp_q [$];
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .DEPTH     (8),
    .RESET_PC  (32'h0000_0000),
    .NOP       (NOP_W),
    .SKIP_LOAD (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_valid    (if_valid),
    .running     (running)
  );

  // Instruction memory: synchronous write, combinational read.
  always @(posedge clk) if (mem_we) imem[mem_addr[4:2]] <= mem_wdata;
  assign mem_rdata = imem[mem_addr[4:2]];

  // Monitor: one expected snapshot per cycle, compared mid-cycle.
  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{running, ld_ready, mem_we, mem_addr, mem_wdata, if_valid, if_pc, if_instr};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL vec%0d run/rdy/we act=%b%b%b exp=%b%b%b addr act=%h exp=%h wdata act=%h exp=%h valid act=%b exp=%b pc act=%h exp=%h instr act=%h exp=%h",
                 n_vec, a.running, a.ld_ready, a.mem_we, e.running, e.ld_ready, e.mem_we,
                 a.mem_addr, e.mem_addr, a.mem_wdata, e.mem_wdata, a.if_valid, e.if_valid,
                 a.if_pc, e.if_pc, a.if_instr, e.if_instr);
      end
    end
  end

  function automatic obs_t lo(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    lo = '{1'b0, 1'b1, we, addr, wd, 1'b0, 32'h0, NOP_W};
  endfunction

  function automatic obs_t ru(input logic [31:0] addr, input logic v, input logic [31:0] pc,
                              input logic [31:0] ins);
    ru = '{1'b1, 1'b0, 1'b0, addr, 32'h0, v, pc, ins};
  endfunction

  // Apply one cycle of inputs after the edge and queue the snapshot expected this cycle.
  task automatic step(input logic rst, input logic lv, input logic [31:0] ld, input logic ll,
                      input logic st, input logic rd, input logic [31:0] rpc, input obs_t e);
    @(posedge clk);
    #1;
    rst_n = rst; ld_valid = lv; ld_data = ld; ld_last = ll;
    stall = st; redirect = rd; redirect_pc = rpc;
    exp_q.push_back(e);
  endtask

  logic [31:0] w [0:4];
  logic [31:0] d [0:9];

  initial begin
    for (int i = 0; i < 8; i++) imem[i] = 32'h0;
    w[0] = 32'h0140_0313; w[1] = 32'h01e0_0393; w[2] = 32'h0073_0e33;
    w[3] = 32'h0000_2e03; w[4] = 32'h01c0_2223;
    for (int i = 0; i < 10; i++) d[i] = 32'hA000_0000 | 32'(i * 17);
    rst_n = 1'b0; ld_valid = 1'b0; ld_data = 32'h0; ld_last = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);

    // Reset state, then LOAD of five words with a gap carrying an ignored redirect.
    step(1, 0, 32'h0,       0, 0, 0, 32'h0,  lo(0, 32'h00, 32'h0));
    step(1, 1, w[0],        0, 0, 0, 32'h0,  lo(1, 32'h00, w[0]));
    step(1, 1, w[1],        0, 0, 0, 32'h0,  lo(1, 32'h04, w[1]));
    step(1, 0, 32'hDEADBEEF,0, 0, 1, 32'h1C, lo(0, 32'h08, 32'hDEADBEEF));
    step(1, 1, w[2],        0, 0, 0, 32'h0,  lo(1, 32'h08, w[2]));
    step(1, 1, w[3],        0, 0, 0, 32'h0,  lo(1, 32'h0C, w[3]));
    step(1, 1, w[4],        1, 0, 0, 32'h0,  lo(1, 32'h10, w[4]));

    // RUN: sequential fetch, loader beats ignored.
    step(1, 1, 32'h1234_5678, 0, 0, 0, 32'h0, ru(32'h00, 0, 32'h00, NOP_W));
    step(1, 0, 32'h0, 0, 0, 0, 32'h0, ru(32'h04, 1, 32'h00, w[0]));
    step(1, 0, 32'h0, 0, 0, 0, 32'h0, ru(32'h08, 1, 32'h04, w[1]));
    // Stall three cycles while if_pc=8.
    step(1, 0, 32'h0, 0, 1, 0, 32'h0, ru(32'h0C, 1, 32'h08, w[2]));
    step(1, 0, 32'h0, 0, 1, 0, 32'h0, ru(32'h0C, 1, 32'h08, w[2]));
    step(1, 0, 32'h0, 0, 1, 0, 32'h0, ru(32'h0C, 1, 32'h08, w[2]));
    step(1, 0, 32'h0, 0, 0, 0, 32'h0, ru(32'h0C, 1, 32'h08, w[2]));
    // Redirect to 0x13 with stall: redirect wins, target aligned to 0x10.
    step(1, 0, 32'h0, 0, 1, 1, 32'h13, ru(32'h10, 1, 32'h0C, w[3]));
    step(1, 0, 32'h0, 0, 0, 0, 32'h0,  ru(32'h10, 0, 32'h10, NOP_W));
    // Reset while running with if_valid=1.
    step(0, 0, 32'h0, 0, 0, 0, 32'h0,  ru(32'h14, 1, 32'h10, w[4]));
    step(1, 0, 32'h0, 0, 0, 0, 32'h0,  lo(0, 32'h00, 32'h0));

    // Ten beats, no ld_last: only eight accepted, then RUN.
    for (int i = 0; i < 8; i++)
      step(1, 1, d[i], 0, 0, 0, 32'h0, lo(1, 32'(i * 4), d[i]));
    step(1, 1, d[8], 0, 0, 0, 32'h0, ru(32'h00, 0, 32'h00, NOP_W));
    step(1, 1, d[9], 0, 0, 0, 32'h0, ru(32'h04, 1, 32'h00, d[0]));
    // Redirect to the last word, then wrap from 28 to 0.
    step(1, 0, 32'h0, 0, 0, 1, 32'h1C, ru(32'h08, 1, 32'h04, d[1]));
    step(1, 0, 32'h0, 0, 0, 0, 32'h0,  ru(32'h1C, 0, 32'h08, NOP_W));
    step(1, 0, 32'h0, 0, 0, 0, 32'h0,  ru(32'h00, 1, 32'h1C, d[7]));
    // Redirect with high bits set: only the in-range word offset survives.
    step(1, 0, 32'h0, 0, 0, 1, 32'hFFFF_FFE5, ru(32'h04, 1, 32'h00, d[0]));
    step(1, 0, 32'h0, 0, 0, 0, 32'h0,  ru(32'h04, 0, 32'h04, NOP_W));
    step(1, 0, 32'h0, 0, 1, 0, 32'h0,  ru(32'h08, 1, 32'h04, d[1]));

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending act=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
